// File: rtl/dcache_pkg.sv
// Shared constants and FSM encoding for the direct-mapped write-back data cache.
package dcache_pkg;

   localparam int ADDR_W_DEF    = 32;
   localparam int LINE_BITS_DEF = 256;
   localparam int NUM_LINES_DEF = 32;
   localparam int LINE_BYTES    = LINE_BITS_DEF / 8;
   localparam int WORD_W        = 32;
   localparam int OFFSET_W      = 5;
   localparam int WORD_SEL_W    = 3;
   localparam int IDX_W_DEF     = $clog2(NUM_LINES_DEF);
   localparam int TAG_W_DEF     = ADDR_W_DEF - OFFSET_W - IDX_W_DEF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WB     = 2'd1,
      FETCH  = 2'd2,
      REFILL = 2'd3
   } state_t;

   function automatic int tag_width(input int addr_w, input int num_lines);
      return addr_w - OFFSET_W - $clog2(num_lines);
   endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: asynchronous read, one synchronous write port.
module dcache_sram
   import dcache_pkg::*;
#(
   parameter int NUM_LINES = NUM_LINES_DEF,
   parameter int IDX_W     = IDX_W_DEF,
   parameter int TAG_W     = TAG_W_DEF,
   parameter int LINE_BITS = LINE_BITS_DEF
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [IDX_W-1:0]     rd_idx,
   output logic                 rd_valid,
   output logic                 rd_dirty,
   output logic [TAG_W-1:0]     rd_tag,
   output logic [LINE_BITS-1:0] rd_data,
   input  logic                 we,
   input  logic [IDX_W-1:0]     wr_idx,
   input  logic                 wr_dirty,
   input  logic [TAG_W-1:0]     wr_tag,
   input  logic [LINE_BITS-1:0] wr_data
);

   logic                 valid_q [NUM_LINES];
   logic                 dirty_q [NUM_LINES];
   logic [TAG_W-1:0]     tag_q   [NUM_LINES];
   logic [LINE_BITS-1:0] data_q  [NUM_LINES];

   assign rd_valid = valid_q[rd_idx];
   assign rd_dirty = dirty_q[rd_idx];
   assign rd_tag   = tag_q[rd_idx];
   assign rd_data  = data_q[rd_idx];

   // Any write (refill or store hit) leaves the line valid.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < NUM_LINES; i++) begin
            valid_q[i] <= 1'b0;
            dirty_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            data_q[i]  <= '0;
         end
      end else if (we) begin
         valid_q[wr_idx] <= 1'b1;
         dirty_q[wr_idx] <= wr_dirty;
         tag_q[wr_idx]   <= wr_tag;
         data_q[wr_idx]  <= wr_data;
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// MEM-stage data cache controller: hit/stall logic, miss FSM (write-back, refill),
// store word merge and saturating hit/miss counters.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int NUM_LINES = 32,
   parameter int LINE_BITS = 256,
   parameter int ADDR_W    = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cpu_req_i,
   input  logic                 cpu_write_i,
   input  logic [ADDR_W-1:0]    cpu_addr_i,
   input  logic [31:0]          cpu_wdata_i,
   output logic [31:0]          cpu_rdata_o,
   output logic                 mem_stall_o,
   output logic                 mem_enable_o,
   output logic                 mem_write_o,
   output logic [ADDR_W-1:0]    mem_addr_o,
   output logic [LINE_BITS-1:0] mem_wdata_o,
   input  logic [LINE_BITS-1:0] mem_rdata_i,
   input  logic                 mem_ack_i,
   output logic [15:0]          hit_cnt_o,
   output logic [15:0]          miss_cnt_o
);

   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;

   state_t                state;
   logic [IDX_W-1:0]      idx, req_idx, wr_idx;
   logic [TAG_W-1:0]      tag, req_tag, line_tag, wr_tag;
   logic [WORD_SEL_W-1:0] word_sel;
   logic [7:0]            bit_sel;
   logic                  line_valid, line_dirty, hit;
   logic                  refill_we, store_we, sram_we;
   logic [LINE_BITS-1:0]  line_data, merged_line, wr_data;
   logic                  unused_addr_bits;

   assign idx              = cpu_addr_i[OFFSET_W +: IDX_W];
   assign tag              = cpu_addr_i[ADDR_W-1 -: TAG_W];
   assign word_sel         = cpu_addr_i[OFFSET_W-1 -: WORD_SEL_W];
   assign bit_sel          = {word_sel, 5'd0};
   assign unused_addr_bits = ^cpu_addr_i[OFFSET_W-WORD_SEL_W-1:0];

   assign hit         = cpu_req_i & line_valid & (line_tag == tag);
   assign mem_stall_o = rst_i & cpu_req_i & (~hit | (state != IDLE));
   assign cpu_rdata_o = hit ? line_data[bit_sel +: WORD_W] : '0;

   always_comb begin
      merged_line                    = line_data;
      merged_line[bit_sel +: WORD_W] = cpu_wdata_i;
   end

   // Refill and store-hit writes never coincide: stores only complete in IDLE.
   assign refill_we = (state == FETCH) & mem_ack_i;
   assign store_we  = (state == IDLE) & hit & cpu_write_i;
   assign sram_we   = refill_we | store_we;
   assign wr_idx    = refill_we ? req_idx : idx;
   assign wr_tag    = refill_we ? req_tag : tag;
   assign wr_data   = refill_we ? mem_rdata_i : merged_line;

   dcache_sram #(
      .NUM_LINES (NUM_LINES),
      .IDX_W     (IDX_W),
      .TAG_W     (TAG_W),
      .LINE_BITS (LINE_BITS)
   ) u_sram (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .rd_idx   (idx),
      .rd_valid (line_valid),
      .rd_dirty (line_dirty),
      .rd_tag   (line_tag),
      .rd_data  (line_data),
      .we       (sram_we),
      .wr_idx   (wr_idx),
      .wr_dirty (store_we),
      .wr_tag   (wr_tag),
      .wr_data  (wr_data)
   );

   // Request index/tag are latched so the refill completes even if cpu_req_i drops.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state        <= IDLE;
         mem_enable_o <= 1'b0;
         mem_write_o  <= 1'b0;
         mem_addr_o   <= '0;
         mem_wdata_o  <= '0;
         req_idx      <= '0;
         req_tag      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cpu_req_i && !hit) begin
                  req_idx      <= idx;
                  req_tag      <= tag;
                  mem_enable_o <= 1'b1;
                  if (line_valid && line_dirty) begin
                     state       <= WB;
                     mem_write_o <= 1'b1;
                     mem_addr_o  <= {line_tag, idx, {OFFSET_W{1'b0}}};
                     mem_wdata_o <= line_data;
                  end else begin
                     state       <= FETCH;
                     mem_write_o <= 1'b0;
                     mem_addr_o  <= {tag, idx, {OFFSET_W{1'b0}}};
                  end
               end
            end
            WB: begin
               if (mem_ack_i) begin
                  state       <= FETCH;
                  mem_write_o <= 1'b0;
                  mem_addr_o  <= {req_tag, req_idx, {OFFSET_W{1'b0}}};
               end
            end
            FETCH: begin
               if (mem_ack_i) begin
                  state        <= REFILL;
                  mem_enable_o <= 1'b0;
               end
            end
            REFILL:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         hit_cnt_o  <= '0;
         miss_cnt_o <= '0;
      end else begin
         if ((state == IDLE) && hit && (hit_cnt_o != 16'hFFFF))
            hit_cnt_o <= hit_cnt_o + 16'd1;
         if ((state == IDLE) && cpu_req_i && !hit && (miss_cnt_o != 16'hFFFF))
            miss_cnt_o <= miss_cnt_o + 16'd1;
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a line-level cache/memory model predicts every
// CPU completion and memory transaction; separate monitors compare them.
module tb_dcache_ctrl;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b0;
   logic         cpu_req_i = 1'b0;
   logic         cpu_write_i = 1'b0;
   logic [31:0]  cpu_addr_i = '0;
   logic [31:0]  cpu_wdata_i = '0;
   logic [31:0]  cpu_rdata_o;
   logic         mem_stall_o;
   logic         mem_enable_o;
   logic         mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_wdata_o;
   logic [255:0] mem_rdata_i = '0;
   logic         mem_ack_i = 1'b0;
   logic [15:0]  hit_cnt_o;
   logic [15:0]  miss_cnt_o;

   dcache_ctrl #(.NUM_LINES(32), .LINE_BITS(256), .ADDR_W(32)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .cpu_req_i    (cpu_req_i),
      .cpu_write_i  (cpu_write_i),
      .cpu_addr_i   (cpu_addr_i),
      .cpu_wdata_i  (cpu_wdata_i),
      .cpu_rdata_o  (cpu_rdata_o),
      .mem_stall_o  (mem_stall_o),
      .mem_enable_o (mem_enable_o),
      .mem_write_o  (mem_write_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_rdata_i  (mem_rdata_i),
      .mem_ack_i    (mem_ack_i),
      .hit_cnt_o    (hit_cnt_o),
      .miss_cnt_o   (miss_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] rdata;
      int          stalls;
      logic [15:0] hits;
      logic [15:0] misses;
   } cpu_exp_t;

   typedef struct {
      logic         write;
      logic [31:0]  addr;
      logic [255:0] wdata;
   } mem_exp_t;

   cpu_exp_t     cpu_q[$];
   mem_exp_t     mem_q[$];
   int           lat_q[$];
   logic [255:0] ref_mem [int unsigned];
   logic [255:0] tb_mem  [int unsigned];

   bit           m_valid [32];
   bit           m_dirty [32];
   int unsigned  m_la    [32];
   logic [255:0] m_data  [32];
   int unsigned  m_hits = 0;
   int unsigned  m_misses = 0;

   int          tests_run = 0;
   int          fails = 0;
   bit          mon_en = 1'b1;
   int          spurious_req = 0;
   int unsigned tags[4] = '{0, 1, 2, 32'h003F_FFFF};

   function automatic logic [255:0] init_line(input logic [31:0] a);
      logic [255:0] l;
      for (int w = 0; w < 8; w++)
         l[w*32 +: 32] = a ^ (32'h0101_0101 * w) ^ 32'hA5A5_0000;
      return l;
   endfunction

   function automatic logic [255:0] ref_line(input int unsigned la);
      if (ref_mem.exists(la)) return ref_mem[la];
      return init_line(la);
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      m_hits   = 0;
      m_misses = 0;
   endfunction

   // One access in line terms: allocate on miss (writing back a dirty victim), then read/merge.
   function automatic void model_access(input bit wr, input logic [31:0] addr,
                                        input logic [31:0] wdata, input int lw, input int lf);
      int unsigned idx = (addr >> 5) & 31;
      int unsigned la  = addr & ~32'h1F;
      int unsigned w   = (addr >> 2) & 7;
      cpu_exp_t    e;
      mem_exp_t    m;
      e.stalls = 0;
      if (!(m_valid[idx] && m_la[idx] == la)) begin
         if (m_misses < 65535) m_misses++;
         if (m_valid[idx] && m_dirty[idx]) begin
            m.write = 1'b1; m.addr = m_la[idx]; m.wdata = m_data[idx];
            mem_q.push_back(m);
            lat_q.push_back(lw);
            ref_mem[m_la[idx]] = m_data[idx];
            e.stalls += lw;
         end
         m.write = 1'b0; m.addr = la; m.wdata = '0;
         mem_q.push_back(m);
         lat_q.push_back(lf);
         e.stalls += lf + 2;
         m_data[idx]  = ref_line(la);
         m_valid[idx] = 1'b1;
         m_dirty[idx] = 1'b0;
         m_la[idx]    = la;
      end
      e.rdata  = m_data[idx][w*32 +: 32];
      e.hits   = 16'(m_hits);
      e.misses = 16'(m_misses);
      cpu_q.push_back(e);
      if (m_hits < 65535) m_hits++;
      if (wr) begin
         m_data[idx][w*32 +: 32] = wdata;
         m_dirty[idx] = 1'b1;
      end
   endfunction

   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
      tests_run++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic finishRun();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   endtask

   task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input int lw, input int lf, input bit check_first);
      int cycles = 0;
      model_access(wr, addr, wdata, lw, lf);
      cpu_req_i   = 1'b1;
      cpu_write_i = wr;
      cpu_addr_i  = addr;
      cpu_wdata_i = wdata;
      if (check_first) begin
         @(negedge clk_i);
         checkOutput("first_stall", mem_stall_o, 1'b1);
         checkOutput("first_enable", mem_enable_o, 1'b0);
         @(negedge clk_i);
         checkOutput("fetch_enable", mem_enable_o, 1'b1);
         checkOutput("fetch_write", mem_write_o, 1'b0);
         checkOutput("fetch_addr", mem_addr_o, addr & ~32'h1F);
      end
      @(negedge clk_i);
      while (mem_stall_o && cycles < 200) begin
         @(negedge clk_i);
         cycles++;
      end
      if (mem_stall_o) begin
         tests_run++;
         fails++;
         $display("[TB] FAIL stall_timeout: addr %h still stalled after %0d cycles, limit 200", addr, cycles);
         finishRun();
      end
      @(posedge clk_i);
      #1;
   endtask

   initial begin : cpu_monitor
      int       stall_cnt = 0;
      cpu_exp_t e;
      forever begin
         @(negedge clk_i);
         if (!mon_en || !rst_i) stall_cnt = 0;
         else if (cpu_req_i) begin
            if (mem_stall_o) stall_cnt++;
            else if (cpu_q.size() == 0) begin
               tests_run++;
               fails++;
               $display("[TB] FAIL scoreboard: completion at addr %h, expected no completion", cpu_addr_i);
               stall_cnt = 0;
            end else begin
               e = cpu_q.pop_front();
               checkOutput("rdata", cpu_rdata_o, e.rdata);
               checkOutput("stall_cycles", stall_cnt, e.stalls);
               checkOutput("hit_cnt", hit_cnt_o, e.hits);
               checkOutput("miss_cnt", miss_cnt_o, e.misses);
               stall_cnt = 0;
            end
         end
      end
   end

   // Off-chip memory: each new request is checked against the model, then acked after its latency.
   initial begin : mem_responder
      int       cnt = 0;
      bit       busy = 1'b0;
      int       spurious_done = 0;
      mem_exp_t e;
      forever begin
         @(negedge clk_i);
         mem_ack_i = 1'b0;
         if (!busy && rst_i && mem_enable_o) begin
            busy = 1'b1;
            if (lat_q.size() != 0) cnt = lat_q.pop_front();
            else cnt = 2;
            if (mem_q.size() == 0) begin
               tests_run++;
               fails++;
               $display("[TB] FAIL mem_request: got addr %h write %b, expected no request", mem_addr_o, mem_write_o);
            end else begin
               e = mem_q.pop_front();
               checkOutput("mem_write", mem_write_o, e.write);
               checkOutput("mem_addr", mem_addr_o, e.addr);
               if (e.write) checkOutput("mem_wdata", mem_wdata_o, e.wdata);
            end
            if (mem_write_o) tb_mem[mem_addr_o] = mem_wdata_o;
            else if (tb_mem.exists(mem_addr_o)) mem_rdata_i = tb_mem[mem_addr_o];
            else mem_rdata_i = init_line(mem_addr_o);
         end
         if (busy) begin
            cnt--;
            if (cnt <= 0) begin
               busy = 1'b0;
               mem_ack_i = 1'b1;
            end
         end else if (spurious_req > spurious_done) begin
            spurious_done++;
            mem_rdata_i = {8{32'hBAD0_0BAD}};
            mem_ack_i = 1'b1;
         end
      end
   end

   initial begin : watchdog
      #5_000_000;
      tests_run++;
      fails++;
      $display("[TB] FAIL watchdog: simulation time limit reached before end of stimulus");
      finishRun();
   end

   initial begin : driver
      logic [255:0] l;
      logic [31:0]  a;
      int           cycles;
      model_reset();
      l = init_line(32'h40);
      l[95:64] = 32'hDEAD_BEEF;
      ref_mem[32'h40] = l;
      tb_mem[32'h40]  = l;

      cpu_req_i  = 1'b1;
      cpu_addr_i = 32'h40;
      repeat (3) @(negedge clk_i);
      checkOutput("rst_enable", mem_enable_o, 1'b0);
      checkOutput("rst_write", mem_write_o, 1'b0);
      checkOutput("rst_addr", mem_addr_o, 32'h0);
      checkOutput("rst_wdata", mem_wdata_o, 256'h0);
      checkOutput("rst_rdata", cpu_rdata_o, 32'h0);
      checkOutput("rst_stall", mem_stall_o, 1'b0);
      checkOutput("rst_hit_cnt", hit_cnt_o, 16'h0);
      checkOutput("rst_miss_cnt", miss_cnt_o, 16'h0);
      cpu_req_i = 1'b0;
      @(posedge clk_i);
      #1 rst_i = 1'b1;
      @(posedge clk_i);
      #1;

      applyStimulus(1'b0, 32'h40, 32'h0, 1, 3, 1'b1);
      applyStimulus(1'b0, 32'h48, 32'h0, 1, 1, 1'b0);
      applyStimulus(1'b1, 32'h44, 32'h1234_5678, 1, 1, 1'b0);
      applyStimulus(1'b0, 32'h44, 32'h0, 1, 1, 1'b0);
      applyStimulus(1'b0, 32'h440, 32'h0, 2, 2, 1'b0);

      cpu_req_i = 1'b0;
      spurious_req++;
      repeat (3) @(negedge clk_i);
      checkOutput("spurious_enable", mem_enable_o, 1'b0);
      checkOutput("spurious_stall", mem_stall_o, 1'b0);
      @(posedge clk_i);
      #1;
      applyStimulus(1'b0, 32'h444, 32'h0, 1, 1, 1'b0);

      for (int i = 0; i < 250; i++) begin
         a = (tags[$urandom_range(0, 3)] << 10) | ($urandom_range(0, 7) << 5) | ($urandom_range(0, 7) << 2);
         applyStimulus(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(1, 4), $urandom_range(1, 4), 1'b0);
         repeat ($urandom_range(0, 2)) begin
            cpu_req_i = 1'b0;
            @(posedge clk_i);
            #1;
         end
      end

      // Reset in the middle of a refill; the late ack must be ignored.
      cpu_req_i = 1'b0;
      @(posedge clk_i);
      #1 mon_en = 1'b0;
      model_access(1'b0, 32'hC40, 32'h0, 1, 8);
      cpu_req_i   = 1'b1;
      cpu_write_i = 1'b0;
      cpu_addr_i  = 32'hC40;
      cycles = 0;
      do begin
         @(negedge clk_i);
         cycles++;
      end while (!(mem_enable_o && !mem_write_o) && cycles < 50);
      checkOutput("pre_reset_fetch_addr", mem_addr_o, 32'hC40);
      @(negedge clk_i);
      #2 rst_i = 1'b0;
      #1;
      checkOutput("midrst_enable", mem_enable_o, 1'b0);
      checkOutput("midrst_stall", mem_stall_o, 1'b0);
      checkOutput("midrst_rdata", cpu_rdata_o, 32'h0);
      checkOutput("midrst_addr", mem_addr_o, 32'h0);
      checkOutput("midrst_miss_cnt", miss_cnt_o, 16'h0);
      cpu_req_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b1;
      void'(cpu_q.pop_back());
      model_reset();
      repeat (10) @(negedge clk_i);
      checkOutput("late_ack_enable", mem_enable_o, 1'b0);
      @(posedge clk_i);
      #1 mon_en = 1'b1;
      applyStimulus(1'b0, 32'h40, 32'h0, 1, 2, 1'b1);

      mon_en      = 1'b0;
      cpu_req_i   = 1'b1;
      cpu_write_i = 1'b0;
      cpu_addr_i  = 32'h40;
      repeat (70000) @(posedge clk_i);
      #1 cpu_req_i = 1'b0;
      @(negedge clk_i);
      checkOutput("sat_hit_cnt", hit_cnt_o, 16'hFFFF);
      checkOutput("sat_miss_cnt", miss_cnt_o, 16'(m_misses));

      checkOutput("cpu_q_drained", cpu_q.size(), 0);
      checkOutput("mem_q_drained", mem_q.size(), 0);
      finishRun();
   end

endmodule
